mul_issue_ctrl: RTL and testbench

//  EX-stage multiply controller of the 5-stage RV64 pipeline; sits upstream of the 2-bit booth multiplier.

---
 rtl/mul_issue_ctrl_if.sv | 24 ++
 rtl/mul_issue_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_issue_ctrl_if.sv
// Pipeline-side handshake bundle of the EX-stage multiply controller.
// master: EX/MEM stages; slave: mul_issue_ctrl.
interface mul_issue_ctrl_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      mul_op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, mul_op, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, mul_op, src1, src2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// EX-stage multiply controller: decodes RV64 M-extension multiplies and drives a booth multiplier.
// Define YSYX_22051013_MUL_FUSE_EN to reuse the last 128-bit product for matching operand pairs.
module mul_issue_ctrl #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned MAX_CYC = 40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  mul_issue_ctrl_if.slave pipe,
  output logic            stall_o,
  output logic            err_timeout_o,
  output logic            m_valid_o,
  output logic            m_flush_o,
  output logic [1:0]      m_signed_o,
  output logic            m_mulw_o,
  output logic [XLEN-1:0] m_op1_o,
  output logic [XLEN-1:0] m_op2_o,
  input  logic            m_out_valid_i,
  input  logic [XLEN-1:0] m_hi_i,
  input  logic [XLEN-1:0] m_lo_i
);

  localparam int unsigned CntW = $clog2(MAX_CYC + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_CYC - 1);

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpMulw   = 3'b100;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            m_valid_q;
  logic [1:0]      m_signed_q;
  logic            m_mulw_q;
  logic [XLEN-1:0] m_op1_q;
  logic [XLEN-1:0] m_op2_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] result_q;
  logic [CntW-1:0] cnt_q;
  logic            err_q;

  logic [1:0]      dec_signed;
  logic            dec_mulw;
  logic            dec_rsvd;
  logic [XLEN-1:0] sel_result;
  logic            fuse_hit;
  logic [XLEN-1:0] fuse_result;

  always_comb begin
    dec_signed = 2'b11;
    dec_mulw   = 1'b0;
    dec_rsvd   = 1'b0;
    case (pipe.mul_op)
      OpMul, OpMulh: dec_signed = 2'b11;
      OpMulhsu:      dec_signed = 2'b01;
      OpMulhu:       dec_signed = 2'b00;
      OpMulw:        dec_mulw   = 1'b1;
      default:       dec_rsvd   = 1'b1;
    endcase
  end

  always_comb begin
    sel_result = m_hi_i;
    case (op_q)
      OpMul:   sel_result = m_lo_i;
      OpMulw:  sel_result = {{(XLEN - 32){m_lo_i[31]}}, m_lo_i[31:0]};
      default: sel_result = m_hi_i;
    endcase
  end

`ifdef YSYX_22051013_MUL_FUSE_EN
  logic            cache_vld_q;
  logic [XLEN-1:0] cache_hi_q;
  logic [XLEN-1:0] cache_lo_q;
  logic [XLEN-1:0] cache_op1_q;
  logic [XLEN-1:0] cache_op2_q;
  logic [1:0]      cache_sg_q;
  logic            cache_mulw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q  <= 1'b0;
      cache_hi_q   <= '0;
      cache_lo_q   <= '0;
      cache_op1_q  <= '0;
      cache_op2_q  <= '0;
      cache_sg_q   <= 2'b00;
      cache_mulw_q <= 1'b0;
    end else if (flush_i) begin
      cache_vld_q <= 1'b0;
    end else if (state_q == StIdle && pipe.in_valid && dec_rsvd) begin
      cache_vld_q <= 1'b0;
    end else if (state_q == StWait && m_out_valid_i) begin
      cache_vld_q  <= 1'b1;
      cache_hi_q   <= m_hi_i;
      cache_lo_q   <= m_lo_i;
      cache_op1_q  <= m_op1_q;
      cache_op2_q  <= m_op2_q;
      cache_sg_q   <= m_signed_q;
      cache_mulw_q <= m_mulw_q;
    end
  end

  // The low half of the product is the same for every signedness, so MUL may hit any entry.
  assign fuse_hit = cache_vld_q && !dec_rsvd && !dec_mulw && !cache_mulw_q &&
                    pipe.src1 == cache_op1_q && pipe.src2 == cache_op2_q &&
                    (dec_signed == cache_sg_q || pipe.mul_op == OpMul);
  assign fuse_result = (pipe.mul_op == OpMul) ? cache_lo_q : cache_hi_q;
`else
  assign fuse_hit    = 1'b0;
  assign fuse_result = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_signed_q  <= 2'b00;
      m_mulw_q    <= 1'b0;
      m_op1_q     <= '0;
      m_op2_q     <= '0;
      op_q        <= OpMul;
      result_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      m_valid_q <= 1'b0;
      if (flush_i) begin
        // Drops a simultaneous request and discards a simultaneous multiplier result.
        state_q     <= StIdle;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (pipe.in_valid) begin
              op_q       <= pipe.mul_op;
              in_ready_q <= 1'b0;
              if (dec_rsvd) begin
                state_q     <= StDone;
                out_valid_q <= 1'b1;
                result_q    <= '0;
              end else if (fuse_hit) begin
                state_q     <= StDone;
                out_valid_q <= 1'b1;
                result_q    <= fuse_result;
              end else begin
                state_q    <= StLaunch;
                m_valid_q  <= 1'b1;
                m_op1_q    <= pipe.src1;
                m_op2_q    <= pipe.src2;
                m_signed_q <= dec_signed;
                m_mulw_q   <= dec_mulw;
              end
            end
          end
          StLaunch: begin
            state_q <= StWait;
            cnt_q   <= '0;
          end
          StWait: begin
            if (m_out_valid_i) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              result_q    <= sel_result;
            end else if (cnt_q != CntMax) begin
              // Saturates at the limit; only a flush leaves a hung multiply.
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == CntLast) begin
                err_q <= 1'b1;
              end
            end
          end
          StDone: begin
            if (pipe.out_ready) begin
              state_q     <= StIdle;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pipe.in_ready  = in_ready_q;
  assign pipe.out_valid = out_valid_q;
  assign pipe.result    = result_q;

  assign stall_o       = pipe.in_valid & ~(state_q == StDone & pipe.out_ready);
  assign err_timeout_o = err_q;
  assign m_valid_o     = m_valid_q;
  assign m_flush_o     = flush_i & (state_q == StLaunch || state_q == StWait);
  assign m_signed_o    = m_signed_q;
  assign m_mulw_o      = m_mulw_q;
  assign m_op1_o       = m_op1_q;
  assign m_op2_o       = m_op2_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: behavioural 33-cycle multiplier, vector table,
// result scoreboard and directed flush/backpressure/timeout/fuse sequences.
module tb_mul_issue_ctrl;

  localparam int unsigned MulLat = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        m_valid, m_flush, m_mulw, err_timeout, stall;
  logic [1:0]  m_signed;
  logic [63:0] m_op1, m_op2;
  logic        m_out_valid;
  logic [63:0] m_hi, m_lo;

  mul_issue_ctrl_if #(.XLEN(64)) pipe ();

  mul_issue_ctrl #(.XLEN(64), .MAX_CYC(40)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .pipe          (pipe),
    .stall_o       (stall),
    .err_timeout_o (err_timeout),
    .m_valid_o     (m_valid),
    .m_flush_o     (m_flush),
    .m_signed_o    (m_signed),
    .m_mulw_o      (m_mulw),
    .m_op1_o       (m_op1),
    .m_op2_o       (m_op2),
    .m_out_valid_i (m_out_valid),
    .m_hi_i        (m_hi),
    .m_lo_i        (m_lo)
  );

  always #5 clk = ~clk;

  // Behavioural booth multiplier: answers MulLat cycles after the launch cycle.
  function automatic logic [127:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sg);
    logic signed [128:0] ea, eb, p;
    ea = sg[0] ? {{65{a[63]}}, a} : {65'b0, a};
    eb = sg[1] ? {{65{b[63]}}, b} : {65'b0, b};
    p  = ea * eb;
    return p[127:0];
  endfunction

  logic         mb_busy = 1'b0;
  int           mb_cnt = 0;
  logic [127:0] mb_prod = '0;
  bit           hang = 1'b0;

  always @(posedge clk) begin
    if (rst || m_flush) begin
      mb_busy     <= 1'b0;
      mb_cnt      <= 0;
      m_out_valid <= 1'b0;
    end else begin
      m_out_valid <= 1'b0;
      if (m_valid) begin
        mb_busy <= 1'b1;
        mb_cnt  <= 1;
        mb_prod <= mul_model(m_op1, m_op2, m_signed);
      end else if (mb_busy) begin
        mb_cnt <= mb_cnt + 1;
        if (mb_cnt == MulLat - 1 && !hang) begin
          m_out_valid <= 1'b1;
          mb_busy     <= 1'b0;
        end
      end
    end
  end
  assign m_hi = mb_prod[127:64];
  assign m_lo = mb_prod[63:0];

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
    bit          launch;
    logic [1:0]  sg;
    logic        mw;
    int          hold;
  } vec_t;

  int          n_checks = 0;
  int          n_errs = 0;
  logic [63:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input vec_t v);
    int          lat;
    int          nval;
    logic [1:0]  sg;
    logic        mw;
    logic [63:0] held;
    bit          stable;
    sb_q.push_back(v.res);
    pipe.in_valid = 1'b1;
    pipe.mul_op   = v.op;
    pipe.src1     = v.a;
    pipe.src2     = v.b;
    #1;
    check({name, " stall"}, stall, 1'b1);
    tick();
    pipe.in_valid = 1'b0;
    lat  = 1;
    nval = 0;
    sg   = 2'bxx;
    mw   = 1'bx;
    while (!pipe.out_valid && lat < 200) begin
      if (m_valid) begin
        nval++;
        sg = m_signed;
        mw = m_mulw;
      end
      tick();
      lat++;
    end
    if (!pipe.out_valid) begin
      check({name, " out_valid wait"}, pipe.out_valid, 1'b1);
      void'(sb_q.pop_front());
      flush = 1'b1;
      tick();
      flush = 1'b0;
      return;
    end
    check({name, " latency"}, 64'(lat), 64'(v.lat));
    check({name, " launches"}, 64'(nval), v.launch ? 64'd1 : 64'd0);
    if (v.launch) begin
      check({name, " m_signed"}, sg, v.sg);
      check({name, " m_mulw"}, mw, v.mw);
    end
    if (v.hold > 0) begin
      pipe.out_ready = 1'b0;
      held   = pipe.result;
      stable = 1'b1;
      for (int i = 0; i < v.hold; i++) begin
        tick();
        if (!pipe.out_valid || pipe.result !== held || pipe.in_ready) stable = 1'b0;
      end
      check({name, " hold stable"}, stable, 1'b1);
      pipe.out_ready = 1'b1;
    end
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 64'd0, 64'd1);
    end else begin
      check({name, " result"}, pipe.result, sb_q.pop_front());
    end
    tick();
    check({name, " back to idle"}, {pipe.out_valid, pipe.in_ready}, 2'b01);
  endtask

  vec_t tbl[9];
  vec_t v;
  bit   seen;
  int   n;

  initial begin
    tbl[0] = '{op: 3'b000, a: 64'd7, b: 64'hFFFF_FFFF_FFFF_FFFD, res: 64'hFFFF_FFFF_FFFF_FFEB,
               lat: 35, launch: 1, sg: 2'b11, mw: 1'b0, hold: 0};
    tbl[1] = '{op: 3'b011, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF,
               res: 64'hFFFF_FFFF_FFFF_FFFE, lat: 35, launch: 1, sg: 2'b00, mw: 1'b0, hold: 5};
    tbl[2] = '{op: 3'b010, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd2, res: 64'hFFFF_FFFF_FFFF_FFFF,
               lat: 35, launch: 1, sg: 2'b01, mw: 1'b0, hold: 0};
    tbl[3] = '{op: 3'b100, a: 64'h7FFF_FFFF, b: 64'd2, res: 64'hFFFF_FFFF_FFFF_FFFE,
               lat: 35, launch: 1, sg: 2'b11, mw: 1'b1, hold: 0};
    tbl[4] = '{op: 3'b001, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, res: 64'd0,
               lat: 35, launch: 1, sg: 2'b11, mw: 1'b0, hold: 0};
    tbl[5] = '{op: 3'b001, a: 64'h4000_0000_0000_0000, b: 64'd4, res: 64'd1,
               lat: 35, launch: 1, sg: 2'b11, mw: 1'b0, hold: 0};
    tbl[6] = '{op: 3'b101, a: 64'd9, b: 64'd9, res: 64'd0,
               lat: 1, launch: 0, sg: 2'b00, mw: 1'b0, hold: 2};
    tbl[7] = '{op: 3'b000, a: 64'h1_0000_0000, b: 64'h1_0000_0000, res: 64'd0,
               lat: 35, launch: 1, sg: 2'b11, mw: 1'b0, hold: 0};
    tbl[8] = '{op: 3'b100, a: 64'd3, b: 64'd5, res: 64'd15,
               lat: 35, launch: 1, sg: 2'b11, mw: 1'b1, hold: 0};

    pipe.in_valid  = 1'b0;
    pipe.mul_op    = 3'b000;
    pipe.src1      = '0;
    pipe.src2      = '0;
    pipe.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset in_ready", pipe.in_ready, 1'b1);
    check("reset out_valid", pipe.out_valid, 1'b0);
    check("reset result", pipe.result, 64'd0);
    check("reset m_valid", m_valid, 1'b0);
    check("reset outs", {m_flush, m_signed, m_mulw, err_timeout, stall}, 6'd0);
    check("reset m_op1", m_op1, 64'd0);

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i]);

    // Flush ten cycles into WAIT, then a fresh op must still complete.
    pipe.in_valid = 1'b1;
    pipe.mul_op   = 3'b000;
    pipe.src1     = 64'd11;
    pipe.src2     = 64'd13;
    tick();
    pipe.in_valid = 1'b0;
    repeat (11) tick();
    flush = 1'b1;
    #1;
    check("flush m_flush", m_flush, 1'b1);
    tick();
    flush = 1'b0;
    #1;
    check("flush idle", {pipe.in_ready, pipe.out_valid, m_flush}, 3'b100);
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (pipe.out_valid || m_valid) seen = 1'b1;
    end
    check("flush no output", seen, 1'b0);
    v = '{op: 3'b000, a: 64'd11, b: 64'd13, res: 64'd143, lat: 35, launch: 1, sg: 2'b11,
          mw: 1'b0, hold: 0};
    run_op("after flush", v);

    // A request arriving with flush in IDLE is dropped.
    pipe.in_valid = 1'b1;
    flush = 1'b1;
    tick();
    pipe.in_valid = 1'b0;
    flush = 1'b0;
    check("idle flush drop", {pipe.in_ready, m_valid}, 2'b10);
    tick();
    check("idle flush no out", pipe.out_valid, 1'b0);

    // Flush while a result is held in DONE.
    pipe.out_ready = 1'b0;
    pipe.in_valid = 1'b1;
    pipe.mul_op   = 3'b110;
    tick();
    pipe.in_valid = 1'b0;
    n = 0;
    while (!pipe.out_valid && n < 10) begin
      tick();
      n++;
    end
    check("done reached", pipe.out_valid, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pipe.out_ready = 1'b1;
    check("done flush", {pipe.out_valid, pipe.in_ready}, 2'b01);

    // Hung multiplier: sticky timeout, flush recovers, rst clears.
    hang = 1'b1;
    pipe.in_valid = 1'b1;
    pipe.mul_op   = 3'b011;
    pipe.src1     = 64'd5;
    pipe.src2     = 64'd6;
    tick();
    pipe.in_valid = 1'b0;
    repeat (30) tick();
    check("timeout early", err_timeout, 1'b0);
    repeat (20) tick();
    check("timeout set", err_timeout, 1'b1);
    check("timeout stays wait", {pipe.in_ready, pipe.out_valid}, 2'b00);
    flush = 1'b1;
    #1;
    check("timeout m_flush", m_flush, 1'b1);
    tick();
    flush = 1'b0;
    hang  = 1'b0;
    check("timeout recover", {pipe.in_ready, err_timeout}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("timeout rst clear", err_timeout, 1'b0);

    // Same operand pair back to back: MULH then MUL, then MULHU (signedness differs).
    v = '{op: 3'b001, a: 64'h1_0000_0001, b: 64'h1_0000_0003, res: 64'd1, lat: 35, launch: 1,
          sg: 2'b11, mw: 1'b0, hold: 0};
    run_op("fuse first", v);
    v.op  = 3'b000;
    v.res = 64'h4_0000_0003;
`ifdef YSYX_22051013_MUL_FUSE_EN
    v.lat    = 1;
    v.launch = 0;
`endif
    run_op("fuse second", v);
    v.op     = 3'b011;
    v.res    = 64'd1;
    v.lat    = 35;
    v.launch = 1;
    v.sg     = 2'b00;
    run_op("fuse miss", v);

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
